// File: rtl/cache_axi_arbiter_pkg.sv
// Shared types for the i/d cache AXI arbiter: FSM states, grant encoding, AXI resp codes.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rstate_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wstate_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  localparam logic [1:0] OKAY = 2'b00;

  // A lone requester always wins; prefer_d only breaks a tie.
  function automatic gnt_t pick2(input logic req_i, input logic req_d, input logic prefer_d);
    if (req_i && req_d) return prefer_d ? GNT_D : GNT_I;
    return req_d ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/cache_axi_arbiter_if.sv
// One full AXI4 port (AR/R/AW/W/B); master modport is the side that issues requests.
interface cache_axi_arbiter_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready
  );
endinterface

// File: rtl/cache_axi_arbiter_arb2_pick.sv
// Two-way tie-break between i and d requesters. AXI_ARB_RR_EN selects round-robin
// with a 1-bit pointer; otherwise fixed priority with d winning ties.
module arb2_pick
  import axi_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_i,
  input  logic i_req_d,
  input  logic i_take,
  output gnt_t o_gnt
);

`ifdef AXI_ARB_RR_EN
  logic r_ptr;

  // Pointer moves away from whoever was just granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_ptr <= 1'b0;
    else if (i_take) r_ptr <= (o_gnt == GNT_I);
  end

  assign o_gnt = pick2(i_req_i, i_req_d, r_ptr);
`else
  logic w_unused;
  assign w_unused = ^{clk, rst, i_take};
  assign o_gnt    = pick2(i_req_i, i_req_d, 1'b1);
`endif

endmodule

// File: rtl/cache_axi_arbiter.sv
// 2:1 AXI arbiter (icache/dcache -> SoC), independent read and write FSMs, whole-burst
// grants with one outstanding burst per channel. Tie policy set by AXI_ARB_RR_EN.
module cache_axi_arbiter
  import axi_arb_pkg::*;
#(
  parameter logic [3:0] ID_I = 4'd0,
  parameter logic [3:0] ID_D = 4'd1
) (
  input logic                  clk,
  input logic                  rst,
  cache_axi_arbiter_if.slave   i,
  cache_axi_arbiter_if.slave   d,
  cache_axi_arbiter_if.master  m
);

  rstate_t r_rstate, w_rnext;
  wstate_t r_wstate, w_wnext;
  gnt_t    r_rgnt, r_wgnt, w_rpick, w_wpick;
  logic    w_rtake, w_wtake, w_rsel_d, w_wsel_d;

  assign w_rtake  = (r_rstate == R_IDLE) && (i.arvalid || d.arvalid);
  assign w_wtake  = (r_wstate == W_IDLE) && (i.awvalid || d.awvalid);
  assign w_rsel_d = (r_rgnt == GNT_D);
  assign w_wsel_d = (r_wgnt == GNT_D);

  arb2_pick u_rpick (
    .clk    (clk),
    .rst    (rst),
    .i_req_i(i.arvalid),
    .i_req_d(d.arvalid),
    .i_take (w_rtake),
    .o_gnt  (w_rpick)
  );

  arb2_pick u_wpick (
    .clk    (clk),
    .rst    (rst),
    .i_req_i(i.awvalid),
    .i_req_d(d.awvalid),
    .i_take (w_wtake),
    .o_gnt  (w_wpick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_wstate <= W_IDLE;
      r_rgnt   <= GNT_I;
      r_wgnt   <= GNT_I;
    end else begin
      r_rstate <= w_rnext;
      r_wstate <= w_wnext;
      if (w_rtake) r_rgnt <= w_rpick;
      if (w_wtake) r_wgnt <= w_wpick;
    end
  end

  // Granted-source views, so the FSM bodies stay source-agnostic.
  logic        w_sarvalid, w_srready, w_sawvalid, w_swvalid, w_swlast, w_sbready;
  logic [31:0] w_saraddr, w_sawaddr, w_swdata;
  logic [7:0]  w_sarlen, w_sawlen;
  logic [2:0]  w_sarsize, w_sawsize;
  logic [1:0]  w_sarburst, w_sawburst;
  logic [3:0]  w_swstrb;

  assign w_sarvalid = w_rsel_d ? d.arvalid : i.arvalid;
  assign w_saraddr  = w_rsel_d ? d.araddr  : i.araddr;
  assign w_sarlen   = w_rsel_d ? d.arlen   : i.arlen;
  assign w_sarsize  = w_rsel_d ? d.arsize  : i.arsize;
  assign w_sarburst = w_rsel_d ? d.arburst : i.arburst;
  assign w_srready  = w_rsel_d ? d.rready  : i.rready;

  assign w_sawvalid = w_wsel_d ? d.awvalid : i.awvalid;
  assign w_sawaddr  = w_wsel_d ? d.awaddr  : i.awaddr;
  assign w_sawlen   = w_wsel_d ? d.awlen   : i.awlen;
  assign w_sawsize  = w_wsel_d ? d.awsize  : i.awsize;
  assign w_sawburst = w_wsel_d ? d.awburst : i.awburst;
  assign w_swvalid  = w_wsel_d ? d.wvalid  : i.wvalid;
  assign w_swdata   = w_wsel_d ? d.wdata   : i.wdata;
  assign w_swstrb   = w_wsel_d ? d.wstrb   : i.wstrb;
  assign w_swlast   = w_wsel_d ? d.wlast   : i.wlast;
  assign w_sbready  = w_wsel_d ? d.bready  : i.bready;

  // Source IDs are replaced by ID_I/ID_D outbound and by 0 inbound.
  logic w_unused;
  assign w_unused = ^{i.arid, d.arid, i.awid, d.awid, m.rid, m.bid};

  always_comb begin
    w_rnext   = r_rstate;
    m.arvalid = 1'b0;
    m.arid    = '0;
    m.araddr  = '0;
    m.arlen   = '0;
    m.arsize  = '0;
    m.arburst = '0;
    m.rready  = 1'b0;
    i.arready = 1'b0;
    i.rvalid  = 1'b0;
    i.rid     = '0;
    i.rdata   = '0;
    i.rresp   = OKAY;
    i.rlast   = 1'b0;
    d.arready = 1'b0;
    d.rvalid  = 1'b0;
    d.rid     = '0;
    d.rdata   = '0;
    d.rresp   = OKAY;
    d.rlast   = 1'b0;
    case (r_rstate)
      R_IDLE: if (w_rtake) w_rnext = R_ADDR;
      R_ADDR: begin
        m.arvalid = w_sarvalid;
        if (w_sarvalid) begin
          m.arid    = w_rsel_d ? ID_D : ID_I;
          m.araddr  = w_saraddr;
          m.arlen   = w_sarlen;
          m.arsize  = w_sarsize;
          m.arburst = w_sarburst;
        end
        if (w_rsel_d) d.arready = m.arready;
        else          i.arready = m.arready;
        if (w_sarvalid && m.arready) w_rnext = R_DATA;
      end
      R_DATA: begin
        m.rready = w_srready;
        if (w_rsel_d) begin
          d.rvalid = m.rvalid;
          if (m.rvalid) begin
            d.rdata = m.rdata;
            d.rresp = m.rresp;
            d.rlast = m.rlast;
          end
        end else begin
          i.rvalid = m.rvalid;
          if (m.rvalid) begin
            i.rdata = m.rdata;
            i.rresp = m.rresp;
            i.rlast = m.rlast;
          end
        end
        if (m.rvalid && w_srready && m.rlast) w_rnext = R_IDLE;
      end
      default: w_rnext = R_IDLE;
    endcase
  end

  always_comb begin
    w_wnext   = r_wstate;
    m.awvalid = 1'b0;
    m.awid    = '0;
    m.awaddr  = '0;
    m.awlen   = '0;
    m.awsize  = '0;
    m.awburst = '0;
    m.wvalid  = 1'b0;
    m.wdata   = '0;
    m.wstrb   = '0;
    m.wlast   = 1'b0;
    m.bready  = 1'b0;
    i.awready = 1'b0;
    i.wready  = 1'b0;
    i.bvalid  = 1'b0;
    i.bid     = '0;
    i.bresp   = OKAY;
    d.awready = 1'b0;
    d.wready  = 1'b0;
    d.bvalid  = 1'b0;
    d.bid     = '0;
    d.bresp   = OKAY;
    case (r_wstate)
      W_IDLE: if (w_wtake) w_wnext = W_ADDR;
      W_ADDR: begin
        m.awvalid = w_sawvalid;
        if (w_sawvalid) begin
          m.awid    = w_wsel_d ? ID_D : ID_I;
          m.awaddr  = w_sawaddr;
          m.awlen   = w_sawlen;
          m.awsize  = w_sawsize;
          m.awburst = w_sawburst;
        end
        if (w_wsel_d) d.awready = m.awready;
        else          i.awready = m.awready;
        if (w_sawvalid && m.awready) w_wnext = W_DATA;
      end
      // W is only opened after AW has been accepted, so early wvalid is held off.
      W_DATA: begin
        m.wvalid = w_swvalid;
        if (w_swvalid) begin
          m.wdata = w_swdata;
          m.wstrb = w_swstrb;
          m.wlast = w_swlast;
        end
        if (w_wsel_d) d.wready = m.wready;
        else          i.wready = m.wready;
        if (w_swvalid && m.wready && w_swlast) w_wnext = W_RESP;
      end
      W_RESP: begin
        m.bready = w_sbready;
        if (w_wsel_d) begin
          d.bvalid = m.bvalid;
          if (m.bvalid) d.bresp = m.bresp;
        end else begin
          i.bvalid = m.bvalid;
          if (m.bvalid) i.bresp = m.bresp;
        end
        if (m.bvalid && w_sbready) w_wnext = W_IDLE;
      end
      default: w_wnext = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: reset, tie-break, i read, concurrent write,
// AR backpressure, mid-burst reset and early-wvalid gating.
module tb_cache_axi_arbiter;
  import axi_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  cache_axi_arbiter_if ic ();
  cache_axi_arbiter_if dc ();
  cache_axi_arbiter_if mm ();

  cache_axi_arbiter dut (.clk(clk), .rst(rst), .i(ic), .d(dc), .m(mm));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] ctl();
    return {mm.arvalid, mm.awvalid, mm.wvalid, mm.rready, mm.bready,
            ic.arready, ic.awready, ic.wready, ic.rvalid, ic.bvalid,
            dc.arready, dc.awready, dc.wready, dc.rvalid, dc.bvalid};
  endfunction

  task automatic idle_inputs();
    ic.arid = '0; ic.araddr = '0; ic.arlen = '0; ic.arsize = '0; ic.arburst = '0; ic.arvalid = 0;
    ic.rready = 0; ic.awid = '0; ic.awaddr = '0; ic.awlen = '0; ic.awsize = '0; ic.awburst = '0;
    ic.awvalid = 0; ic.wdata = '0; ic.wstrb = '0; ic.wlast = 0; ic.wvalid = 0; ic.bready = 0;
    dc.arid = '0; dc.araddr = '0; dc.arlen = '0; dc.arsize = '0; dc.arburst = '0; dc.arvalid = 0;
    dc.rready = 0; dc.awid = '0; dc.awaddr = '0; dc.awlen = '0; dc.awsize = '0; dc.awburst = '0;
    dc.awvalid = 0; dc.wdata = '0; dc.wstrb = '0; dc.wlast = 0; dc.wvalid = 0; dc.bready = 0;
    mm.arready = 0; mm.rid = '0; mm.rdata = '0; mm.rresp = '0; mm.rlast = 0; mm.rvalid = 0;
    mm.awready = 0; mm.wready = 0; mm.bid = '0; mm.bresp = '0; mm.bvalid = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    ic.arvalid = 1'b1;
    dc.awvalid = 1'b1;
    repeat (2) step();
    n_cmp++; if (ctl() !== '0) begin n_err++; $display("FAIL reset_ctl: got %b want 0", ctl()); end
    n_cmp++;
    if ({mm.araddr, mm.awaddr, mm.wdata, mm.arid, mm.awid, mm.wstrb} !== '0) begin
      n_err++; $display("FAIL reset_payload: got %h/%h/%h want 0", mm.araddr, mm.awaddr, mm.wdata);
    end
    ic.arvalid = 1'b0;
    dc.awvalid = 1'b0;
    rst = 1'b0;
    step();
    n_cmp++; if (ctl() !== '0) begin n_err++; $display("FAIL post_reset_idle: got %b want 0", ctl()); end
  endtask

  task automatic test_tie();
    logic        first_d;
    logic [31:0] a1, a2;
    logic [3:0]  id1, id2;
`ifdef AXI_ARB_RR_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    a1  = first_d ? 32'h2000_0000 : 32'h1000_0000;
    a2  = first_d ? 32'h1000_0000 : 32'h2000_0000;
    id1 = first_d ? 4'd1 : 4'd0;
    id2 = first_d ? 4'd0 : 4'd1;
    ic.arvalid = 1; ic.araddr = 32'h1000_0000; ic.arlen = 8'd1; ic.arsize = 3'd2; ic.arburst = 2'b01;
    dc.arvalid = 1; dc.araddr = 32'h2000_0000; dc.arlen = 8'd1; dc.arsize = 3'd2; dc.arburst = 2'b01;
    ic.rready = 1; dc.rready = 1;
    #1;
    n_cmp++; if (mm.arvalid !== 1'b0) begin n_err++; $display("FAIL tie_cycle0: arvalid got %b want 0", mm.arvalid); end
    step();
    mm.arready = 1; #1;
    n_cmp++;
    if ({mm.arvalid, mm.arid, mm.araddr} !== {1'b1, id1, a1}) begin
      n_err++; $display("FAIL tie_first_ar: got id %h addr %h want id %h addr %h", mm.arid, mm.araddr, id1, a1);
    end
    n_cmp++;
    if ({ic.arready, dc.arready} !== (first_d ? 2'b01 : 2'b10)) begin
      n_err++; $display("FAIL tie_first_arready: got %b%b", ic.arready, dc.arready);
    end
    step();
    if (first_d) dc.arvalid = 0; else ic.arvalid = 0;
    mm.arready = 0; mm.rvalid = 1; mm.rdata = 32'h0000_00D0; mm.rlast = 0; #1;
    n_cmp++;
    if ({ic.rvalid, dc.rvalid, mm.arvalid} !== (first_d ? 3'b010 : 3'b100)) begin
      n_err++; $display("FAIL tie_first_route: got i_rvalid %b d_rvalid %b m_arvalid %b", ic.rvalid, dc.rvalid, mm.arvalid);
    end
    step();
    mm.rdata = 32'h0000_00D1; mm.rlast = 1; #1;
    n_cmp++;
    if ((first_d ? {dc.rlast, dc.rdata} : {ic.rlast, ic.rdata}) !== {1'b1, 32'h0000_00D1}) begin
      n_err++; $display("FAIL tie_first_last: got i %b/%h d %b/%h", ic.rlast, ic.rdata, dc.rlast, dc.rdata);
    end
    step();
    mm.rvalid = 0; mm.rlast = 0; mm.rdata = 0; #1;
    n_cmp++; if (mm.arvalid !== 1'b0) begin n_err++; $display("FAIL tie_n1_idle: arvalid got %b want 0", mm.arvalid); end
    step();
    n_cmp++;
    if ({mm.arvalid, mm.arid, mm.araddr} !== {1'b1, id2, a2}) begin
      n_err++; $display("FAIL tie_second_ar: got v %b id %h addr %h want id %h addr %h", mm.arvalid, mm.arid, mm.araddr, id2, a2);
    end
    mm.arready = 1;
    step();
    ic.arvalid = 0; dc.arvalid = 0; mm.arready = 0; mm.rvalid = 1; mm.rlast = 0;
    step();
    mm.rlast = 1;
    step();
    mm.rvalid = 0; mm.rlast = 0; #1;
    n_cmp++; if (ctl() !== '0) begin n_err++; $display("FAIL tie_done_idle: got %b want 0", ctl()); end
    idle_inputs();
  endtask

  task automatic test_i_read();
    logic [31:0] exp;
    ic.arvalid = 1; ic.araddr = 32'hBFC0_0000; ic.arlen = 8'd7; ic.arsize = 3'd2; ic.arburst = 2'b01;
    ic.rready = 1; #1;
    n_cmp++; if (mm.arvalid !== 1'b0) begin n_err++; $display("FAIL iread_cycle0: arvalid got %b want 0", mm.arvalid); end
    step();
    n_cmp++;
    if ({mm.arvalid, mm.arid, mm.araddr, mm.arlen} !== {1'b1, 4'd0, 32'hBFC0_0000, 8'd7}) begin
      n_err++; $display("FAIL iread_ar: got v %b id %h addr %h len %0d", mm.arvalid, mm.arid, mm.araddr, mm.arlen);
    end
    mm.arready = 1; #1;
    n_cmp++; if (ic.arready !== 1'b1) begin n_err++; $display("FAIL iread_arready: got %b want 1", ic.arready); end
    step();
    ic.arvalid = 0; ic.araddr = 0; mm.arready = 0;
    for (int b = 0; b < 8; b++) begin
      exp = 32'hCAFE_0000 + 32'(b);
      mm.rvalid = 1; mm.rid = 4'h7; mm.rdata = exp; mm.rresp = OKAY; mm.rlast = (b == 7); #1;
      n_cmp++;
      if ({ic.rvalid, ic.rid, ic.rdata, ic.rlast, dc.rvalid, mm.rready} !== {1'b1, 4'd0, exp, (b == 7), 1'b0, 1'b1}) begin
        n_err++; $display("FAIL iread_beat%0d: got v %b id %h data %h last %b d_rvalid %b", b, ic.rvalid, ic.rid, ic.rdata, ic.rlast, dc.rvalid);
      end
      step();
    end
    mm.rvalid = 0; mm.rlast = 0; mm.rid = 0; mm.rdata = 0; #1;
    n_cmp++;
    if ({ic.rvalid, ic.rdata, mm.rready} !== '0) begin
      n_err++; $display("FAIL iread_after: got rvalid %b rdata %h rready %b want 0", ic.rvalid, ic.rdata, mm.rready);
    end
    idle_inputs();
  endtask

  task automatic test_write_concurrent();
    dc.awvalid = 1; dc.awaddr = 32'h1FAF_0000; dc.awlen = 8'd3; dc.awsize = 3'd2; dc.awburst = 2'b01;
    dc.bready = 1;
    ic.arvalid = 1; ic.araddr = 32'h0000_4000; ic.arlen = 8'd3; ic.arsize = 3'd2; ic.arburst = 2'b01;
    ic.rready = 1;
    step();
    n_cmp++;
    if ({mm.awvalid, mm.awid, mm.awaddr, mm.awlen, mm.arvalid, mm.arid} !== {1'b1, 4'd1, 32'h1FAF_0000, 8'd3, 1'b1, 4'd0}) begin
      n_err++; $display("FAIL wc_addr: got aw %b/%h/%h/%0d ar %b/%h", mm.awvalid, mm.awid, mm.awaddr, mm.awlen, mm.arvalid, mm.arid);
    end
    mm.awready = 1; mm.arready = 1; #1;
    n_cmp++;
    if ({dc.awready, ic.arready, ic.awready, dc.arready} !== 4'b1100) begin
      n_err++; $display("FAIL wc_readies: got %b%b%b%b want 1100", dc.awready, ic.arready, ic.awready, dc.arready);
    end
    step();
    dc.awvalid = 0; ic.arvalid = 0; mm.awready = 0; mm.arready = 0;
    for (int k = 0; k < 4; k++) begin
      dc.wvalid = 1; dc.wdata = 32'hD000_0000 + 32'(k); dc.wstrb = 4'hF; dc.wlast = (k == 3); mm.wready = 1;
      mm.rvalid = 1; mm.rdata = 32'h0000_A000 + 32'(k); mm.rlast = (k == 3); #1;
      n_cmp++;
      if ({mm.wvalid, mm.wdata, mm.wstrb, mm.wlast, dc.wready, ic.rvalid, ic.rdata}
          !== {1'b1, 32'hD000_0000 + 32'(k), 4'hF, (k == 3), 1'b1, 1'b1, 32'h0000_A000 + 32'(k)}) begin
        n_err++; $display("FAIL wc_beat%0d: got w %b/%h/%h/%b wready %b r %b/%h", k, mm.wvalid, mm.wdata, mm.wstrb, mm.wlast, dc.wready, ic.rvalid, ic.rdata);
      end
      step();
    end
    dc.wvalid = 0; dc.wlast = 0; mm.wready = 0; mm.rvalid = 0; mm.rlast = 0;
    mm.bvalid = 1; mm.bresp = OKAY; mm.bid = 4'h1; #1;
    n_cmp++;
    if ({dc.bvalid, dc.bresp, dc.bid, mm.bready, ic.bvalid, ic.rvalid} !== {1'b1, OKAY, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL wc_bresp: got d_bvalid %b bresp %b bready %b i_bvalid %b", dc.bvalid, dc.bresp, mm.bready, ic.bvalid);
    end
    step();
    mm.bvalid = 0; mm.bid = 0; #1;
    n_cmp++; if (ctl() !== '0) begin n_err++; $display("FAIL wc_idle: got %b want 0", ctl()); end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    ic.arvalid = 1; ic.araddr = 32'h8000_0040; ic.arlen = 8'd0; ic.arsize = 3'd2; ic.arburst = 2'b01;
    ic.rready = 1;
    step();
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if ({mm.arvalid, mm.araddr, ic.arready} !== {1'b1, 32'h8000_0040, 1'b0}) begin
        n_err++; $display("FAIL bp_hold%0d: got v %b addr %h arready %b", c, mm.arvalid, mm.araddr, ic.arready);
      end
      step();
    end
    mm.arready = 1; #1;
    n_cmp++;
    if ({mm.arvalid, mm.araddr, ic.arready} !== {1'b1, 32'h8000_0040, 1'b1}) begin
      n_err++; $display("FAIL bp_accept: got v %b addr %h arready %b", mm.arvalid, mm.araddr, ic.arready);
    end
    step();
    ic.arvalid = 0; mm.arready = 0; mm.rvalid = 1; mm.rlast = 1; #1;
    n_cmp++; if (ic.arready !== 1'b0) begin n_err++; $display("FAIL bp_arready_drop: got %b want 0", ic.arready); end
    step();
    idle_inputs();
  endtask

  task automatic test_reset_midburst();
    ic.arvalid = 1; ic.araddr = 32'h0000_8000; ic.arlen = 8'd7; ic.arsize = 3'd2; ic.arburst = 2'b01;
    ic.rready = 1;
    step();
    mm.arready = 1;
    step();
    ic.arvalid = 0; mm.arready = 0; mm.rvalid = 1; mm.rdata = 32'h0000_0001;
    step();
    mm.rdata = 32'h0000_0002;
    step();
    mm.rdata = 32'h0000_0003; #1;
    n_cmp++; if (ic.rvalid !== 1'b1) begin n_err++; $display("FAIL rstmid_beat3: rvalid got %b want 1", ic.rvalid); end
    rst = 1'b1; #1;
    n_cmp++;
    if ({ctl(), ic.rdata} !== '0) begin
      n_err++; $display("FAIL rstmid_async: got ctl %b rdata %h want 0", ctl(), ic.rdata);
    end
    step();
    idle_inputs();
    step();
    rst = 1'b0;
    ic.arvalid = 1; ic.araddr = 32'h0000_9000; ic.arlen = 8'd0; ic.rready = 1;
    step();
    n_cmp++;
    if ({mm.arvalid, mm.arid, mm.araddr} !== {1'b1, 4'd0, 32'h0000_9000}) begin
      n_err++; $display("FAIL rstmid_regrant: got v %b id %h addr %h", mm.arvalid, mm.arid, mm.araddr);
    end
    mm.arready = 1;
    step();
    ic.arvalid = 0; mm.arready = 0; mm.rvalid = 1; mm.rlast = 1;
    step();
    idle_inputs();
  endtask

  task automatic test_early_wvalid();
    dc.awvalid = 1; dc.awaddr = 32'h0000_0100; dc.awlen = 8'd0; dc.awsize = 3'd2; dc.awburst = 2'b01;
    dc.wvalid = 1; dc.wdata = 32'h5555_AAAA; dc.wstrb = 4'hF; dc.wlast = 1; dc.bready = 1;
    mm.wready = 1; #1;
    n_cmp++; if ({dc.wready, mm.wvalid} !== 2'b00) begin n_err++; $display("FAIL ew_idle: got wready %b m_wvalid %b", dc.wready, mm.wvalid); end
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if ({mm.awvalid, dc.wready, mm.wvalid, mm.wdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
        n_err++; $display("FAIL ew_hold%0d: got awvalid %b wready %b m_wvalid %b wdata %h", c, mm.awvalid, dc.wready, mm.wvalid, mm.wdata);
      end
    end
    step();
    mm.awready = 1; #1;
    n_cmp++;
    if ({dc.awready, dc.wready, mm.wvalid} !== 3'b100) begin
      n_err++; $display("FAIL ew_aw_hs: got awready %b wready %b m_wvalid %b", dc.awready, dc.wready, mm.wvalid);
    end
    step();
    dc.awvalid = 0; mm.awready = 0; #1;
    n_cmp++;
    if ({mm.wvalid, mm.wdata, mm.wlast, dc.wready} !== {1'b1, 32'h5555_AAAA, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL ew_wdata: got v %b data %h last %b wready %b", mm.wvalid, mm.wdata, mm.wlast, dc.wready);
    end
    step();
    dc.wvalid = 0; dc.wlast = 0; mm.wready = 0; mm.bvalid = 1; mm.bresp = OKAY; #1;
    n_cmp++; if ({dc.bvalid, mm.bready} !== 2'b11) begin n_err++; $display("FAIL ew_b: got bvalid %b bready %b", dc.bvalid, mm.bready); end
    step();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_tie();
    test_i_read();
    test_write_concurrent();
    test_backpressure();
    test_reset_midburst();
    test_early_wvalid();
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_axi_arbiter.md
# cache_axi_arbiter

Two-to-one AXI master arbiter between the instruction cache and data cache AXI ports and the single CPU-side AXI master toward the SoC interconnect. It sits directly below `i_cache` and `d_cache` in `myCPU`. Read and write channels are arbitrated independently, and each channel allows one outstanding burst. Every transaction is granted as a whole burst and is never interleaved.

## Interface
Parameters:
- ID_I, 4'd0, ARID/AWID driven on the m-side for i-side transactions
- ID_D, 4'd1, ARID/AWID driven on the m-side for d-side transactions

Ports (per-channel payloads listed as groups; `x` = `i` or `d`):
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- x_arid/x_araddr/x_arlen/x_arsize/x_arburst  in  4/32/8/3/2  source read-address payload
- x_arvalid  in  1 / x_arready  out  1  source AR handshake
- x_rid/x_rdata/x_rresp/x_rlast  out  4/32/2/1  read data returned to the source
- x_rvalid  out  1 / x_rready  in  1  source R handshake
- x_awid/x_awaddr/x_awlen/x_awsize/x_awburst  in  4/32/8/3/2  source write-address payload
- x_awvalid  in  1 / x_awready  out  1  source AW handshake
- x_wdata/x_wstrb/x_wlast  in  32/4/1  source write data
- x_wvalid  in  1 / x_wready  out  1  source W handshake
- x_bid/x_bresp  out  4/2  write response; x_bvalid  out  1 / x_bready  in  1
- m_ar*, m_r*, m_aw*, m_w*, m_b*  mirror set  same widths  AXI master port toward the SoC (directions inverted)

## Operation
- Read FSM: R_IDLE → R_ADDR → R_DATA → R_IDLE.
  - In R_IDLE, if any x_arvalid is high, the arbiter registers the grant and moves to R_ADDR.
  - In R_ADDR, the granted source's AR is routed to the m-side combinationally, with m_arid = ID_I or ID_D. The FSM leaves R_ADDR on m_arvalid & m_arready.
  - In R_DATA, m_r* is routed to the granted source, with x_rid = 0. The FSM leaves R_DATA on m_rvalid & m_rready & m_rlast.
- Write FSM: W_IDLE → W_ADDR → W_DATA → W_RESP → W_IDLE.
  - The FSM leaves W_DATA on the wlast handshake and leaves W_RESP on the B handshake.
  - A source wvalid asserted before W_DATA is not forwarded; its x_wready stays 0 until W_DATA.
- Non-granted sources see x_*ready = 0 and x_rvalid = x_bvalid = 0.
- The m-side payload is driven to 0 whenever the corresponding m_*valid is low.
- Read and write FSMs run concurrently. The i-side can read while the d-side writes, and the d-side can read while its own write is in W_RESP.
- Arbitration on a tie (both valid in IDLE): see Configuration. A single requester is granted regardless of priority.
- Burst length and beat count are taken from the source. The arbiter does no counting and relies on m_rlast and x_wlast.

## Timing
- Reset values:
  - Both FSMs are in IDLE.
  - All m_*valid, m_rready, m_bready, x_*ready, x_rvalid and x_bvalid are 0.
  - All payloads are 0.
  - The round-robin pointer is 0.
- Grant latency: x_arvalid seen in cycle 0 (IDLE) → m_arvalid high in cycle 1. The same holds for AW.
- Data path is zero-latency combinational pass-through; there is no skid buffer.
- Back-to-back: a last-beat handshake in cycle N gives IDLE in N+1 and a new m_*valid in N+2.
- Backpressure:
  - m_arvalid and its payload stay stable while m_arready = 0, because the source holds them per AXI.
  - Payload must not switch source until the handshake completes.
- Reset asserted mid-burst:
  - All outputs go to their reset values immediately (asynchronously) and both FSMs go to IDLE.
  - The remaining beats are abandoned.

## Configuration
- AXI_ARB_RR_EN defined: round-robin arbitration, with a separate 1-bit pointer per channel (read, write).
  - Pointer = 0: i-side wins a tie. Pointer = 1: d-side wins a tie.
  - After each grant, the pointer points away from the source just granted.
- AXI_ARB_RR_EN undefined: fixed priority, d-side always wins a tie. The pointer register is not built.

## Structure
- Package `axi_arb_pkg`: read and write state enums, grant encoding (GNT_I = 0, GNT_D = 1), AXI resp constant OKAY = 2'b00.
- Sub-module `arb2_pick`: the 2-way tie-break (fixed or RR plus pointer), instantiated once for read and once for write.

## Test plan
- i-side only read, araddr 0xBFC00000, arlen 7 → m_arvalid in cycle 1 with m_arid 0; 8 beats delivered on i_r*; d_rvalid stays 0.
- i and d reads in the same cycle:
  - Fixed priority → d granted first (m_arid 1); i's AR is issued 2 cycles after d's rlast.
  - With AXI_ARB_RR_EN → i is granted first, then d.
- d write, awaddr 0x1FAF0000, awlen 3, 4 beats with wstrb 0xF, bresp OKAY → d_bvalid on the B handshake. A concurrent i read (arlen 3) completes without stalling.
- m_arready held low for 5 cycles → m_arvalid and m_araddr stay stable all 5 cycles; i_arready pulses only on the accepting cycle.
- rst asserted during read beat 3 of 8 → all valid and ready signals are 0 in the same cycle. After release, a fresh i read is granted in cycle 1.
- d_wvalid raised 2 cycles before m_awready → d_wready stays 0 until W_DATA, and no m_wvalid precedes the AW handshake.
